// File: rtl/pcie_rate_pkg.sv
// -----------------------------------------------------------------------------
// pcie_rate_pkg
//   Shared PCIe rate definitions used by the rate-change controller, mainLTSSM
//   and the TX path.
//   Contents:
//     ST_*          state encodings of the PIPE rate-change sequencer
//     rateState_t   enum built on those encodings (exposed on the debug port)
//     GEN1..GEN5    PCIe generation codes as carried on target_gen/current_gen
//     genToRate     GEN code -> 4-bit PIPE Rate value (gen-1)
//     genToPclkRate GEN code -> 5-bit PIPE PCLKRate value ({2'b00, gen-1})
// -----------------------------------------------------------------------------
package pcie_rate_pkg;

  // Sequencer state encodings. Kept as plain localparams so that other blocks
  // and checkers can decode the debug state without depending on the enum.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_QUIESCE  = 3'd1;
  localparam logic [2:0] ST_SET_RATE = 3'd2;
  localparam logic [2:0] ST_WAIT_OK  = 3'd3;
  localparam logic [2:0] ST_ACK      = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  typedef enum logic [2:0] {
    RATE_IDLE     = ST_IDLE,
    RATE_QUIESCE  = ST_QUIESCE,
    RATE_SET_RATE = ST_SET_RATE,
    RATE_WAIT_OK  = ST_WAIT_OK,
    RATE_ACK      = ST_ACK,
    RATE_DONE     = ST_DONE
  } rateState_t;

  // Generation codes.
  localparam logic [2:0] GEN1 = 3'd1;
  localparam logic [2:0] GEN2 = 3'd2;
  localparam logic [2:0] GEN3 = 3'd3;
  localparam logic [2:0] GEN4 = 3'd4;
  localparam logic [2:0] GEN5 = 3'd5;

  // PIPE Rate: Gen1 = 0, Gen2 = 1, ... Gen5 = 4. Callers only pass legal
  // (non-zero) generation codes.
  function automatic logic [3:0] genToRate(input logic [2:0] gen);
    logic [2:0] idx;
    idx = gen - 3'd1;
    return {1'b0, idx};
  endfunction

  // PIPE PCLKRate: same index, zero-extended to the 5-bit field.
  function automatic logic [4:0] genToPclkRate(input logic [2:0] gen);
    logic [2:0] idx;
    idx = gen - 3'd1;
    return {2'b00, idx};
  endfunction

endpackage

// File: rtl/pipe_rate_change_ctrl_phystatus_collector.sv
// -----------------------------------------------------------------------------
// phystatus_collector
//   Sticky per-lane record of PhyStatus pulses during the PCLK-change
//   acknowledge phase. A lane counts as seen once it has pulsed at least once
//   since the last clear; lanes outside the mask are never recorded and never
//   block completion.
//   Ports:
//     pclk       in   PIPE clock
//     reset_n    in   asynchronous active-low reset
//     clear      in   synchronous clear of the sticky record (held while the
//                     sequencer is outside the acknowledge phase)
//     PhyStatus  in   per-lane completion pulses from the PHY
//     mask       in   lanes taking part in the rate change
//     all_seen   out  every masked lane has pulsed, counting the current cycle
// -----------------------------------------------------------------------------
module phystatus_collector #(
  parameter int LANESNUMBER = 16
) (
  input  logic                   pclk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic [LANESNUMBER-1:0] PhyStatus,
  input  logic [LANESNUMBER-1:0] mask,
  output logic                   all_seen
);

  logic [LANESNUMBER-1:0] seenQ;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      seenQ <= '0;
    end else if (clear) begin
      seenQ <= '0;
    end else begin
      seenQ <= seenQ | (PhyStatus & mask);
    end
  end

  // The live PhyStatus is folded in so the last lane to report completes the
  // phase in the same cycle it pulses.
  assign all_seen = ((seenQ | PhyStatus) & mask) == mask;

endmodule

// File: rtl/pipe_rate_change_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_rate_change_ctrl
//   Sequences a PIPE rate change when the LTSSM requests a new generation:
//   quiesces TX, programs Rate/PCLKRate, completes the PclkChangeOk /
//   PclkChangeAck handshake and waits for PhyStatus on every participating
//   lane before reporting completion.
//
//   Request handshake: rate_req is a level that is only looked at while the
//   block is idle (rate_busy=0). Each sampled request is answered by exactly
//   one single-cycle pulse, rate_done (change finished or nothing to do) or
//   rate_err (rejected, or watchdog expiry), never both in one cycle. Once a
//   change has started, rate_req is ignored until the block is idle again.
//
//   Optional feature: define PIPE_RATE_TIMEOUT_EN to enable a watchdog on the
//   QUIESCE, WAIT_OK and ACK states. After TIMEOUT_CYCLES cycles in one of
//   those states the change is abandoned: rate_err pulses, TX is released,
//   PclkChangeAck drops and Rate/PCLKRate return to the current generation.
//   Without the macro the block waits indefinitely.
//
//   Parameters:
//     LANESNUMBER     number of PIPE lanes
//     MAX_GEN         highest legal target generation (1..5)
//     TIMEOUT_CYCLES  watchdog limit per waiting state (watchdog builds only)
//   Ports:
//     pclk           in   PIPE clock, all logic on the rising edge
//     reset_n        in   asynchronous active-low reset
//     rate_req       in   rate-change request level from the LTSSM
//     target_gen     in   requested generation, sampled with rate_req
//     active_lanes   in   participating lanes, sampled with rate_req
//     TxElecIdle     in   per-lane electrical-idle status from TX
//     PclkChangeOk   in   PHY ready for the PCLK change
//     PhyStatus      in   per-lane completion pulses from the PHY
//     Rate           out  PIPE Rate (gen-1)
//     PCLKRate       out  PIPE PCLKRate ({2'b00, gen-1})
//     PclkChangeAck  out  PCLK-change acknowledge to the PHY
//     tx_hold        out  holds TX in electrical idle during the change
//     rate_busy      out  high whenever the sequencer is not idle
//     rate_done      out  single-cycle completion pulse
//     rate_err       out  single-cycle reject/timeout pulse
//     current_gen    out  generation currently programmed
//     stateDbg       out  sequencer state, for debug and checkers
// -----------------------------------------------------------------------------
module pipe_rate_change_ctrl
  import pcie_rate_pkg::*;
#(
  parameter int LANESNUMBER    = 16,
  parameter int MAX_GEN        = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   pclk,
  input  logic                   reset_n,
  input  logic                   rate_req,
  input  logic [2:0]             target_gen,
  input  logic [LANESNUMBER-1:0] active_lanes,
  input  logic [LANESNUMBER-1:0] TxElecIdle,
  input  logic                   PclkChangeOk,
  input  logic [LANESNUMBER-1:0] PhyStatus,
  output logic [3:0]             Rate,
  output logic [4:0]             PCLKRate,
  output logic                   PclkChangeAck,
  output logic                   tx_hold,
  output logic                   rate_busy,
  output logic                   rate_done,
  output logic                   rate_err,
  output logic [2:0]             current_gen,
  output rateState_t             stateDbg
);

  localparam logic [2:0] MaxGenL = 3'(MAX_GEN);

  rateState_t             state;
  logic [2:0]             targetQ;   // generation being programmed
  logic [LANESNUMBER-1:0] maskQ;     // lanes taking part in this change

  logic reqInvalid;
  logic reqNoop;
  logic quiesced;
  logic allSeen;
  logic collectClear;

  assign reqInvalid = (target_gen == 3'd0) || (target_gen > MaxGenL) ||
                      (active_lanes == '0);
  assign reqNoop    = (target_gen == current_gen);
  assign quiesced   = ((TxElecIdle & maskQ) == maskQ);
  assign stateDbg   = state;

  // The record is held clear everywhere except ACK, so it is empty on the
  // ACK entry cycle and PhyStatus seen before the acknowledge never counts.
  assign collectClear = (state != RATE_ACK);

  phystatus_collector #(
    .LANESNUMBER(LANESNUMBER)
  ) u_collector (
    .pclk     (pclk),
    .reset_n  (reset_n),
    .clear    (collectClear),
    .PhyStatus(PhyStatus),
    .mask     (maskQ),
    .all_seen (allSeen)
  );

`ifdef PIPE_RATE_TIMEOUT_EN
  localparam int              CntW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] waitCnt;
  logic            inWait;
  logic            progress;
  logic            timeoutHit;

  assign inWait   = (state == RATE_QUIESCE) || (state == RATE_WAIT_OK) ||
                    (state == RATE_ACK);
  assign progress = ((state == RATE_QUIESCE) && quiesced)     ||
                    ((state == RATE_WAIT_OK) && PclkChangeOk) ||
                    ((state == RATE_ACK)     && allSeen);
  // Forward progress wins over expiry in the same cycle.
  assign timeoutHit = inWait && !progress && (waitCnt == CntLast);

  // Every state entry comes from progress, an abort or leaving IDLE, so
  // counting only while stalled in a waiting state restarts it on each entry.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      waitCnt <= '0;
    end else if (inWait && !progress && !timeoutHit) begin
      waitCnt <= waitCnt + CntW'(1);
    end else begin
      waitCnt <= '0;
    end
  end
`endif

  // Sequencer with registered outputs: each output takes its value on the
  // edge that enters the state where it applies.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RATE_IDLE;
      targetQ       <= GEN1;
      maskQ         <= '0;
      Rate          <= genToRate(GEN1);
      PCLKRate      <= genToPclkRate(GEN1);
      PclkChangeAck <= 1'b0;
      tx_hold       <= 1'b0;
      rate_busy     <= 1'b0;
      rate_done     <= 1'b0;
      rate_err      <= 1'b0;
      current_gen   <= GEN1;
    end else begin
      rate_done <= 1'b0;
      rate_err  <= 1'b0;
`ifdef PIPE_RATE_TIMEOUT_EN
      if (timeoutHit) begin
        // Abandon the change and fall back to the generation still in use.
        state         <= RATE_IDLE;
        rate_err      <= 1'b1;
        PclkChangeAck <= 1'b0;
        tx_hold       <= 1'b0;
        rate_busy     <= 1'b0;
        Rate          <= genToRate(current_gen);
        PCLKRate      <= genToPclkRate(current_gen);
      end else begin
`endif
        case (state)
          RATE_IDLE: begin
            if (rate_req) begin
              if (reqInvalid) begin
                rate_err <= 1'b1;
              end else if (reqNoop) begin
                rate_done <= 1'b1;
              end else begin
                targetQ   <= target_gen;
                maskQ     <= active_lanes;
                tx_hold   <= 1'b1;
                rate_busy <= 1'b1;
                state     <= RATE_QUIESCE;
              end
            end
          end

          RATE_QUIESCE: begin
            if (quiesced) begin
              Rate     <= genToRate(targetQ);
              PCLKRate <= genToPclkRate(targetQ);
              state    <= RATE_SET_RATE;
            end
          end

          RATE_SET_RATE: begin
            state <= RATE_WAIT_OK;
          end

          RATE_WAIT_OK: begin
            if (PclkChangeOk) begin
              PclkChangeAck <= 1'b1;
              state         <= RATE_ACK;
            end
          end

          RATE_ACK: begin
            if (allSeen) begin
              PclkChangeAck <= 1'b0;
              tx_hold       <= 1'b0;
              rate_done     <= 1'b1;
              current_gen   <= targetQ;
              state         <= RATE_DONE;
            end
          end

          RATE_DONE: begin
            rate_busy <= 1'b0;
            state     <= RATE_IDLE;
          end

          default: begin
            PclkChangeAck <= 1'b0;
            tx_hold       <= 1'b0;
            rate_busy     <= 1'b0;
            state         <= RATE_IDLE;
          end
        endcase
`ifdef PIPE_RATE_TIMEOUT_EN
      end
`endif
    end
  end

endmodule

// File: tb/tb_pipe_rate_change_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_rate_change_ctrl
//   Self-checking bench for pipe_rate_change_ctrl (LANESNUMBER=16, MAX_GEN=3,
//   TIMEOUT_CYCLES=16). Each rate change is described by its stall lengths;
//   the expected output timeline is derived from those with plain arithmetic.
//   Cycle n of a scenario is the cycle after the n-th rising edge following
//   the cycle in which the request is presented (n=0). Inputs are driven and
//   outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_rate_change_ctrl;
  import pcie_rate_pkg::*;

  localparam int LANES = 16;
  localparam int MAXG  = 3;
  localparam int TOUT  = 16;
`ifdef PIPE_RATE_TIMEOUT_EN
  localparam int LONG_WAIT = 12;
`else
  localparam int LONG_WAIT = 20;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             pclk = 1'b0;
  logic             reset_n;
  logic             rate_req;
  logic [2:0]       target_gen;
  logic [LANES-1:0] active_lanes;
  logic [LANES-1:0] TxElecIdle;
  logic             PclkChangeOk;
  logic [LANES-1:0] PhyStatus;
  logic [3:0]       Rate;
  logic [4:0]       PCLKRate;
  logic             PclkChangeAck;
  logic             tx_hold;
  logic             rate_busy;
  logic             rate_done;
  logic             rate_err;
  logic [2:0]       current_gen;
  rateState_t       stateDbg;

  always #5 pclk = ~pclk;

  pipe_rate_change_ctrl #(
    .LANESNUMBER   (LANES),
    .MAX_GEN       (MAXG),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .pclk         (pclk),
    .reset_n      (reset_n),
    .rate_req     (rate_req),
    .target_gen   (target_gen),
    .active_lanes (active_lanes),
    .TxElecIdle   (TxElecIdle),
    .PclkChangeOk (PclkChangeOk),
    .PhyStatus    (PhyStatus),
    .Rate         (Rate),
    .PCLKRate     (PCLKRate),
    .PclkChangeAck(PclkChangeAck),
    .tx_hold      (tx_hold),
    .rate_busy    (rate_busy),
    .rate_done    (rate_done),
    .rate_err     (rate_err),
    .current_gen  (current_gen),
    .stateDbg     (stateDbg)
  );

  // Observed vector: busy,hold,ack,done,err,Rate[4],PCLKRate[5],gen[3],state[3]
  logic [19:0] obs;
  assign obs = {rate_busy, tx_hold, PclkChangeAck, rate_done, rate_err,
                Rate, PCLKRate, current_gen, stateDbg};

  int         checks   = 0;
  int         failures = 0;
  logic [2:0] modelGen;   // generation the reference model says is programmed

  // ---------------- reference model helpers ----------------
  function automatic logic [19:0] expVec(input logic busy, input logic hold,
                                         input logic ack, input logic done,
                                         input logic err, input logic [2:0] rateGen,
                                         input logic [2:0] cur, input logic [2:0] st);
    logic [3:0] r;
    logic [4:0] p;
    r = 4'(rateGen) - 4'd1;
    p = 5'(rateGen) - 5'd1;
    return {busy, hold, ack, done, err, r, p, cur, st};
  endfunction

  function automatic logic [2:0] pickOtherGen(input logic [2:0] cur);
    logic [2:0] g;
    g = 3'($urandom_range(1, MAXG));
    while (g == cur) g = 3'($urandom_range(1, MAXG));
    return g;
  endfunction

  task automatic idle_inputs();
    rate_req     = 1'b0;
    target_gen   = 3'd1;
    active_lanes = '0;
    TxElecIdle   = '1;
    PclkChangeOk = 1'b0;
    PhyStatus    = '0;
  endtask

  // ---------------- driver + inline checks: generic rate change ----------------
  // qD: extra QUIESCE cycles, okD: extra WAIT_OK cycles, off[l]: ACK cycle in
  // which masked lane l pulses PhyStatus (0 = ACK entry cycle).
  task automatic run_change(input string name, input logic [2:0] tgt,
                            input logic [LANES-1:0] mask, input int qD, input int okD,
                            input int holdLane, input int off[LANES]);
    int a, d, lastOff;
    logic [2:0] oldGen, st, rg, cg;
    logic [19:0] e;
    logic [LANES-1:0] idle, phy;
    oldGen  = modelGen;
    a       = 4 + qD + okD;          // ACK entry cycle
    lastOff = 0;
    for (int l = 0; l < LANES; l++) if (mask[l] && off[l] > lastOff) lastOff = off[l];
    d = a + lastOff + 1;             // DONE cycle
    @(posedge pclk); #1;
    for (int n = 0; n <= d + 1; n++) begin
      if (n > 0) begin
        @(posedge pclk); #1;
        if      (n <= 1 + qD) st = ST_QUIESCE;
        else if (n == 2 + qD) st = ST_SET_RATE;
        else if (n < a)       st = ST_WAIT_OK;
        else if (n < d)       st = ST_ACK;
        else if (n == d)      st = ST_DONE;
        else                  st = ST_IDLE;
        rg = (n >= 2 + qD) ? tgt : oldGen;
        cg = (n >= d) ? tgt : oldGen;
        e  = expVec(n <= d, n < d, (n >= a) && (n < d), n == d, 1'b0, rg, cg, st);
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL %s cycle %0d: got=%05h want=%05h (busy,hold,ack,done,err,Rate,PCLKRate,gen,state)",
                   name, n, obs, e);
        end
      end
      // Inputs for cycle n. Requests after n=0 must be ignored by a busy DUT.
      if (n == 0) begin
        rate_req     = 1'b1;
        target_gen   = tgt;
        active_lanes = mask;
      end else begin
        rate_req     = (n < d) ? 1'($urandom_range(0, 1)) : 1'b0;
        target_gen   = 3'($urandom_range(0, 7));
        active_lanes = LANES'($urandom);
      end
      idle = LANES'($urandom);
      if (n >= 1 + qD) idle = idle | mask;
      else             idle[holdLane] = 1'b0;
      TxElecIdle = idle;
      if (n >= 3 + qD + okD) PclkChangeOk = 1'b1;
      else if (n < 3 + qD)   PclkChangeOk = 1'($urandom_range(0, 1));
      else                   PclkChangeOk = 1'b0;
      phy = LANES'($urandom);     // noise on unmasked lanes and before ACK
      if (n >= a)
        for (int l = 0; l < LANES; l++) if (mask[l]) phy[l] = (n == a + off[l]);
      PhyStatus = phy;
    end
    modelGen = tgt;
    idle_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge pclk); #1;
      rate_req     = 1'($urandom_range(0, 1));
      target_gen   = 3'($urandom_range(0, 7));
      active_lanes = LANES'($urandom);
      TxElecIdle   = LANES'($urandom);
      PclkChangeOk = 1'($urandom_range(0, 1));
      PhyStatus    = LANES'($urandom);
      #3;
      checks++;
      if (obs !== expVec(0, 0, 0, 0, 0, GEN1, GEN1, ST_IDLE)) begin
        failures++;
        $display("FAIL reset_values cycle %0d: got=%05h want=%05h", i, obs,
                 expVec(0, 0, 0, 0, 0, GEN1, GEN1, ST_IDLE));
      end
    end
    idle_inputs();
    @(posedge pclk); #1;
    reset_n  = 1'b1;
    modelGen = GEN1;
  endtask

  task automatic test_gen_change();
    int off[LANES];
    logic [LANES-1:0] mask;
    int hl;
    // Gen1 -> Gen2, all lanes, every condition immediately true.
    for (int l = 0; l < LANES; l++) off[l] = 0;
    run_change("gen1_to_gen2", GEN2, '1, 0, 0, 0, off);
    // Randomized changes with random stalls and lane masks.
    for (int it = 0; it < 8; it++) begin
      mask = LANES'($urandom);
      if (mask == '0) mask = LANES'(1);
      hl = $urandom_range(0, LANES - 1);
      while (!mask[hl]) hl = $urandom_range(0, LANES - 1);
      for (int l = 0; l < LANES; l++) off[l] = $urandom_range(0, 6);
      run_change("random_change", pickOtherGen(modelGen), mask,
                 $urandom_range(0, 3), $urandom_range(0, 3), hl, off);
    end
  endtask

  task automatic test_staggered();
    int off[LANES];
    for (int l = 0; l < LANES; l++) off[l] = (l < 4) ? 0 : (l < 8) ? 5 : 0;
    run_change("staggered_phystatus", pickOtherGen(modelGen), 16'h00FF, 0, 0, 0, off);
    // Lane 5 stays silent for a long time: ACK must be held until it reports.
    off[5] = LONG_WAIT;
    run_change("lane5_late", pickOtherGen(modelGen), 16'h00FF, 0, 0, 0, off);
  endtask

  task automatic test_invalid();
    logic [2:0] tg[5];
    logic [LANES-1:0] ln[5];
    logic isDone[5];
    logic [19:0] e;
    tg[0] = 3'd0;       ln[0] = '1;     isDone[0] = 1'b0;
    tg[1] = 3'd4;       ln[1] = '1;     isDone[1] = 1'b0;
    tg[2] = 3'd7;       ln[2] = 16'h1;  isDone[2] = 1'b0;
    tg[3] = modelGen;   ln[3] = '1;     isDone[3] = 1'b1;
    tg[4] = pickOtherGen(modelGen); ln[4] = '0; isDone[4] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge pclk); #1;
      rate_req = 1'b1; target_gen = tg[c]; active_lanes = ln[c];
      @(posedge pclk); #1;
      idle_inputs();
      e = expVec(0, 0, 0, isDone[c], !isDone[c], modelGen, modelGen, ST_IDLE);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL invalid_req_%0d pulse: got=%05h want=%05h", c, obs, e);
      end
      @(posedge pclk); #1;
      e = expVec(0, 0, 0, 0, 0, modelGen, modelGen, ST_IDLE);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL invalid_req_%0d after: got=%05h want=%05h", c, obs, e);
      end
    end
  endtask

  task automatic test_quiesce_gate();
    int off[LANES];
    for (int l = 0; l < LANES; l++) off[l] = $urandom_range(0, 3);
    run_change("quiesce_gate_lane3", pickOtherGen(modelGen), '1, LONG_WAIT, 0, 3, off);
  endtask

`ifdef PIPE_RATE_TIMEOUT_EN
  // stall: 0 = QUIESCE never satisfied, 1 = PclkChangeOk never, 2 = no PhyStatus
  task automatic test_timeout(input int stall);
    int entry, errC;
    logic [2:0] tgt, oldGen, st, rg;
    logic [19:0] e;
    oldGen = modelGen;
    tgt    = pickOtherGen(modelGen);
    entry  = (stall == 0) ? 1 : (stall == 1) ? 3 : 4;
    errC   = entry + TOUT;
    @(posedge pclk); #1;
    for (int n = 0; n <= errC + 1; n++) begin
      if (n > 0) begin
        @(posedge pclk); #1;
        if (n >= errC)                 st = ST_IDLE;
        else if (stall == 0 || n == 1) st = ST_QUIESCE;
        else if (n == 2)               st = ST_SET_RATE;
        else if (stall == 1 || n == 3) st = ST_WAIT_OK;
        else                           st = ST_ACK;
        rg = (stall != 0 && n >= 2 && n < errC) ? tgt : oldGen;
        e  = expVec(n < errC, n < errC, (stall == 2) && (n >= 4) && (n < errC),
                    1'b0, n == errC, rg, oldGen, st);
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL timeout_stall%0d cycle %0d: got=%05h want=%05h", stall, n, obs, e);
        end
      end
      rate_req     = (n == 0);
      target_gen   = tgt;
      active_lanes = '1;
      TxElecIdle   = (stall == 0) ? 16'hFFF7 : '1;
      PclkChangeOk = (stall != 1);
      PhyStatus    = '0;
    end
    idle_inputs();
  endtask
`endif

  task automatic test_mid_ack_reset();
    logic [2:0] tgt;
    tgt = pickOtherGen(modelGen);
    @(posedge pclk); #1;
    rate_req = 1'b1; target_gen = tgt; active_lanes = '1;
    TxElecIdle = '1; PclkChangeOk = 1'b1; PhyStatus = '0;
    for (int n = 1; n <= 5; n++) begin
      @(posedge pclk); #1;
      rate_req = 1'b0;
    end
    // Cycle 5: ACK is waiting on PhyStatus that never comes.
    checks++;
    if (obs !== expVec(1, 1, 1, 0, 0, tgt, modelGen, ST_ACK)) begin
      failures++;
      $display("FAIL mid_ack_pre_reset: got=%05h want=%05h", obs,
               expVec(1, 1, 1, 0, 0, tgt, modelGen, ST_ACK));
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== expVec(0, 0, 0, 0, 0, GEN1, GEN1, ST_IDLE)) begin
      failures++;
      $display("FAIL mid_ack_async_reset: got=%05h want=%05h", obs,
               expVec(0, 0, 0, 0, 0, GEN1, GEN1, ST_IDLE));
    end
    idle_inputs();
    @(posedge pclk); #1;
    reset_n  = 1'b1;
    modelGen = GEN1;
    @(posedge pclk); #1;
    checks++;
    if (obs !== expVec(0, 0, 0, 0, 0, GEN1, GEN1, ST_IDLE)) begin
      failures++;
      $display("FAIL mid_ack_after_release: got=%05h want=%05h", obs,
               expVec(0, 0, 0, 0, 0, GEN1, GEN1, ST_IDLE));
    end
  endtask

  task automatic test_back_to_back();
    int off[LANES];
    for (int l = 0; l < LANES; l++) off[l] = 0;
    run_change("b2b_first", pickOtherGen(modelGen), '1, 0, 0, 0, off);
    run_change("b2b_second", pickOtherGen(modelGen), 16'h8001, 1, 2, 15, off);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset_n  = 1'b0;
    modelGen = GEN1;
    idle_inputs();
    test_reset();
    test_gen_change();
    test_staggered();
    test_invalid();
    test_quiesce_gate();
`ifdef PIPE_RATE_TIMEOUT_EN
    test_timeout(0);
    test_timeout(1);
    test_timeout(2);
`endif
    test_back_to_back();
    test_mid_ack_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

endmodule
